line_mem_ctrl: RTL and testbench



---
 rtl/line_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_line_mem_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/line_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// line_mem_ctrl : line backing store with clocked write-back / fill handshake
// Rev 1.0
// ----------------------------------------------------------------------------
module line_mem_ctrl #(
  parameter int LINE_BITS = 1024,
  parameter int LINES     = 64,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wb,
  input  logic                 req_fill,
  input  logic [31:0]          wb_addr,
  input  logic [LINE_BITS-1:0] wb_data,
  input  logic [31:0]          fill_addr,
  output logic                 resp_valid,
  output logic [LINE_BITS-1:0] resp_data,
  output logic                 busy,
  input  logic                 flush_req,
  output logic                 flush_done
);

  localparam int         IDX_W      = $clog2(LINES);
  localparam logic [7:0] C_CNT_LAST = 8'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB   = 3'd1,
    FILL = 3'd2,
    RESP = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 fill_flag_q;
  logic [IDX_W-1:0]     wb_idx_q, fill_idx_q;
  logic [LINE_BITS-1:0] wb_data_q;
  logic [LINE_BITS-1:0] resp_data_q;
  logic [LINE_BITS-1:0] mem_q [LINES];

  logic w_accept;
  logic w_last;
  logic w_unused_addr;

  assign w_unused_addr = ^{wb_addr[31:IDX_W+7], wb_addr[6:0],
                           fill_addr[31:IDX_W+7], fill_addr[6:0]};

  assign req_ready  = (state_q == IDLE) && !flush_req;
  assign w_accept   = req_valid && req_ready;
  assign w_last     = (cnt_q == C_CNT_LAST);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q == WB) || (state_q == FILL) || (state_q == RESP);
  // Drops combinationally with flush_req, one cycle before HALT is left.
  assign flush_done = (state_q == HALT) && flush_req;
  assign resp_data  = resp_data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = HALT;
        end else if (req_valid) begin
          cnt_d = 8'd0;
          if (req_wb)        state_d = WB;
          else if (req_fill) state_d = FILL;
          else               state_d = RESP;
        end
      end
      WB: begin
        if (w_last) begin
          cnt_d   = 8'd0;
          state_d = fill_flag_q ? FILL : RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FILL: begin
        if (w_last) begin
          cnt_d   = 8'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      HALT:    if (!flush_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      fill_flag_q <= 1'b0;
      wb_idx_q    <= '0;
      fill_idx_q  <= '0;
      wb_data_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        fill_flag_q <= req_fill;
        wb_idx_q    <= wb_addr[IDX_W+6:7];
        fill_idx_q  <= fill_addr[IDX_W+6:7];
        wb_data_q   <= wb_data;
      end
      // Response data changes only on the edge entering RESP.
      if (state_q == FILL && w_last) begin
        resp_data_q <= mem_q[fill_idx_q];
      end else if ((state_q == WB && w_last && !fill_flag_q) ||
                   (w_accept && !req_wb && !req_fill)) begin
        resp_data_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == WB && w_last) begin
      mem_q[wb_idx_q] <= wb_data_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_line_mem_ctrl : directed vector bench for line_mem_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_line_mem_ctrl;

  localparam int LB = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wb, req_fill;
  logic [31:0]   wb_addr, fill_addr;
  logic [LB-1:0] wb_data, resp_data;
  logic          resp_valid, busy, flush_req, flush_done;

  int errors = 0;
  int checks = 0;

  line_mem_ctrl #(.LINE_BITS(LB), .LINES(64), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_fill(req_fill),
    .wb_addr(wb_addr), .wb_data(wb_data), .fill_addr(fill_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          wb;
    logic          fill;
    logic [31:0]   wa;
    logic [LB-1:0] wd;
    logic [31:0]   fa;
    int            lat;
    logic [LB-1:0] rd;
  } vec_t;

  vec_t vecs[9];

  logic [LB-1:0] pA, pB, pC, pD, pE, pF;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (low 256 bits)", name, act[255:0], exp[255:0]);
    end
  endtask

  task automatic launch(input logic wb, input logic fill, input logic [31:0] wa,
                        input logic [LB-1:0] wd, input logic [31:0] fa);
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_wb = wb; req_fill = fill;
    wb_addr = wa; wb_data = wd; fill_addr = fa;
    @(posedge clk);
    #1;
    // Scramble inputs after accept to prove they were captured.
    req_valid = 1'b0; req_wb = ~wb; req_fill = ~fill;
    wb_addr = ~wa; wb_data = ~wd; fill_addr = ~fa;
  endtask

  task automatic do_txn(input vec_t v);
    int   k;
    logic seen, busy_ok;
    launch(v.wb, v.fill, v.wa, v.wd, v.fa);
    k = 0; seen = 1'b0; busy_ok = 1'b1;
    while (k < 40 && !seen) begin
      @(negedge clk);
      k++;
      if (resp_valid) seen = 1'b1;
      if (!busy) busy_ok = 1'b0;
    end
    chk({v.name, " latency"}, LB'(k), LB'(v.lat));
    chk({v.name, " busy"}, LB'(busy_ok), LB'(1));
    chk({v.name, " resp_data"}, resp_data, v.rd);
    @(negedge clk);
    chk({v.name, " pulse end"}, LB'(resp_valid), LB'(0));
    chk({v.name, " idle busy"}, LB'(busy), LB'(0));
    chk({v.name, " data hold"}, resp_data, v.rd);
  endtask

  initial begin
    logic any_resp;
    pA = {32{32'hA5A5_0001}};
    pB = {32{32'hB00B_0002}};
    pC = {32{32'hC0DE_0003}};
    pD = {32{32'hD00D_0004}};
    pE = {32{32'hEEEE_0005}};
    pF = {32{32'hF00F_0006}};

    vecs[0] = '{"wb line1 A",        1'b1, 1'b0, 32'h0000_0080, pA, 32'h0,         5, '0};
    vecs[1] = '{"fill line1",        1'b0, 1'b1, 32'h0,         '0, 32'h0000_0080, 5, pA};
    vecs[2] = '{"wb line2 B + fill", 1'b1, 1'b1, 32'h0000_0100, pB, 32'h0000_0080, 9, pA};
    vecs[3] = '{"fill line2",        1'b0, 1'b1, 32'h0,         '0, 32'h0000_0100, 5, pB};
    vecs[4] = '{"same line C",       1'b1, 1'b1, 32'h0000_0200, pC, 32'h0000_0200, 9, pC};
    vecs[5] = '{"wb offset D",       1'b1, 1'b0, 32'h0000_007F, pD, 32'h0,         5, '0};
    vecs[6] = '{"fill alias line0",  1'b0, 1'b1, 32'h0,         '0, 32'h0000_2000, 5, pD};
    vecs[7] = '{"noop",              1'b0, 1'b0, 32'h0,         '0, 32'h0,         1, '0};
    vecs[8] = '{"wb line3 F",        1'b1, 1'b0, 32'h0000_0180, pF, 32'h0,         5, '0};

    rst = 1'b1; req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
    wb_addr = '0; fill_addr = '0; wb_data = '0; flush_req = 1'b0;
    #1;
    chk("reset req_ready",  LB'(req_ready),  LB'(1));
    chk("reset resp_valid", LB'(resp_valid), LB'(0));
    chk("reset resp_data",  resp_data,       '0);
    chk("reset busy",       LB'(busy),       LB'(0));
    chk("reset flush_done", LB'(flush_done), LB'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) do_txn(vecs[i]);

    // Flush raised mid-fill: the pulse still issues, then HALT.
    launch(1'b0, 1'b1, 32'h0, '0, 32'h0000_0100);
    @(negedge clk);
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("flush c4 no resp", LB'(resp_valid), LB'(0));
    @(negedge clk);
    chk("flush c5 resp_valid", LB'(resp_valid), LB'(1));
    chk("flush c5 resp_data",  resp_data, pB);
    chk("flush c5 req_ready",  LB'(req_ready), LB'(0));
    req_valid = 1'b1; req_wb = 1'b0; req_fill = 1'b1;
    @(negedge clk);
    chk("flush c6 req_ready",  LB'(req_ready), LB'(0));
    @(negedge clk);
    chk("flush c7 flush_done", LB'(flush_done), LB'(1));
    chk("flush c7 req_ready",  LB'(req_ready), LB'(0));
    chk("flush c7 busy",       LB'(busy), LB'(0));
    req_valid = 1'b0;
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    chk("unflush done drop",   LB'(flush_done), LB'(0));
    chk("unflush ready low",   LB'(req_ready), LB'(0));
    @(negedge clk);
    chk("unflush ready next",  LB'(req_ready), LB'(1));
    chk("unflush busy",        LB'(busy), LB'(0));

    // Asynchronous reset during a write-back of E to line 3.
    launch(1'b1, 1'b0, 32'h0000_0180, pE, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort req_ready",  LB'(req_ready),  LB'(1));
    chk("abort resp_valid", LB'(resp_valid), LB'(0));
    chk("abort resp_data",  resp_data,       '0);
    chk("abort busy",       LB'(busy),       LB'(0));
    chk("abort flush_done", LB'(flush_done), LB'(0));
    any_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      any_resp |= resp_valid;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_resp |= resp_valid;
    end
    chk("abort no resp", LB'(any_resp), LB'(0));
    vecs[0] = '{"fill line3 after abort", 1'b0, 1'b1, 32'h0, '0, 32'h0000_0180, 5, pF};
    do_txn(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
